// File: rtl/drum_ctrl_pkg.sv
// Shared types and defaults for the drum sweep controller.
package drum_ctrl_pkg;

    localparam int unsigned DEF_NUM_ROWS   = 30;
    localparam int unsigned DEF_CENTER_ROW = 15;
    localparam int unsigned DEF_ADDR_W     = 19;
    localparam int unsigned DATA_W         = 18;
    localparam int unsigned STEP_W         = 16;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_ARMED,
        ST_PRIME,
        ST_PRIME_WAIT,
        ST_LOAD,
        ST_WAIT,
        ST_UPDATE,
        ST_DONE,
        ST_HOLD
    } state_e;

    // Registered per-cycle strobes driven toward the column datapath.
    typedef struct packed {
        logic upd_wr;
        logic load_curr;
        logic shift_en;
        logic bottom_flag;
        logic top_flag;
        logic center_strobe;
        logic step_done;
    } strb_t;

endpackage

// File: rtl/drum_sweep_ctrl_if.sv
// Host/datapath-facing bundle of the drum sweep controller.
interface drum_sweep_ctrl_if
    import drum_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic [DATA_W-1:0] init_data;
    logic              init_valid;
    logic              init_ready;
    logic              run;
    logic              reinit;
    logic              audio_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              init_wr;
    logic              load_curr;
    logic              shift_en;
    logic              bottom_flag;
    logic              top_flag;
    logic              center_strobe;
    logic              step_done;
    logic [STEP_W-1:0] step_cnt;

    // Controller side
    modport master (
        input  init_valid, run, reinit, audio_req,
        output init_ready, rd_addr, wr_addr, wr_en, init_wr, load_curr,
               shift_en, bottom_flag, top_flag, center_strobe, step_done,
               step_cnt
    );

    // Host / datapath side
    modport slave (
        output init_data, init_valid, run, reinit, audio_req,
        input  init_ready, rd_addr, wr_addr, wr_en, init_wr, load_curr,
               shift_en, bottom_flag, top_flag, center_strobe, step_done,
               step_cnt
    );

endinterface

// File: rtl/drum_sweep_ctrl.sv
// Row-sweep sequencer for the drum column M10Ks: init load, per-timestep
// row updates and audio-paced stepping.
module drum_sweep_ctrl
    import drum_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = DEF_NUM_ROWS,
    parameter int unsigned CENTER_ROW = DEF_CENTER_ROW,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    drum_sweep_ctrl_if.master    bus
);

    localparam int unsigned ROW_W = $clog2(NUM_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [ROW_W-1:0] CTR_ROW  = ROW_W'(CENTER_ROW);
    localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W+1)'(NUM_ROWS);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              init_ready_q, init_ready_d;
    strb_t             strb_q, strb_d;
    logic              init_fire_c;
    logic [ROW_W:0]    row_p2;

    // The init write must land in the same cycle as its PIO beat.
    assign init_fire_c = bus.init_valid & init_ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            row_q        <= '0;
            step_cnt_q   <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            init_ready_q <= 1'b0;
            strb_q       <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            step_cnt_q   <= step_cnt_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            init_ready_q <= init_ready_d;
            strb_q       <= strb_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        step_cnt_d   = step_cnt_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        init_ready_d = 1'b0;
        strb_d       = '0;
        row_p2       = '0;

        unique case (state_q)
            ST_INIT: begin
                if (init_fire_c) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = ST_ARMED;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            ST_ARMED: begin
                if (bus.reinit)   state_d = ST_INIT;
                else if (bus.run) state_d = ST_PRIME;
            end
            ST_PRIME:      state_d = ST_PRIME_WAIT;
            ST_PRIME_WAIT: state_d = ST_LOAD;
            ST_LOAD:       state_d = ST_WAIT;
            ST_WAIT:       state_d = ST_UPDATE;
            ST_UPDATE: begin
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_DONE, ST_HOLD: begin
                if (!bus.run)          state_d = ST_ARMED;
                else if (bus.audio_req) state_d = ST_PRIME;
                else                    state_d = ST_HOLD;
            end
            default: state_d = ST_INIT;
        endcase

        // Outputs are registered: decode the state being entered.
        case (state_d)
            ST_INIT: begin
                init_ready_d = 1'b1;
                wr_addr_d    = ADDR_W'(row_d);
            end
            ST_PRIME: rd_addr_d = '0;
            ST_LOAD: begin
                strb_d.load_curr = 1'b1;
                rd_addr_d        = ADDR_W'(1);
            end
            ST_UPDATE: begin
                row_p2               = {1'b0, row_d} + (ROW_W+1)'(2);
                strb_d.upd_wr        = 1'b1;
                strb_d.shift_en      = 1'b1;
                strb_d.bottom_flag   = (row_d == '0);
                strb_d.top_flag      = (row_d == LAST_ROW);
                strb_d.center_strobe = (row_d == CTR_ROW);
                wr_addr_d            = ADDR_W'(row_d);
                rd_addr_d            = (row_p2 < ROWS_EXT) ? ADDR_W'(row_p2) : '0;
            end
            ST_DONE: begin
                strb_d.step_done = 1'b1;
                step_cnt_d       = step_cnt_q + STEP_W'(1);
            end
            default: ;
        endcase
    end

    assign bus.init_ready    = init_ready_q;
    assign bus.rd_addr       = rd_addr_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_en         = strb_q.upd_wr | init_fire_c;
    assign bus.init_wr       = init_fire_c;
    assign bus.load_curr     = strb_q.load_curr;
    assign bus.shift_en      = strb_q.shift_en;
    assign bus.bottom_flag   = strb_q.bottom_flag;
    assign bus.top_flag      = strb_q.top_flag;
    assign bus.center_strobe = strb_q.center_strobe;
    assign bus.step_done     = strb_q.step_done;
    assign bus.step_cnt      = step_cnt_q;

endmodule

// File: tb/tb_drum_sweep_ctrl.sv
// Scoreboard bench for drum_sweep_ctrl: expected writes and step counts are
// queued when stimulus is driven and consumed as the controller emits them.
module tb_drum_sweep_ctrl;
    import drum_ctrl_pkg::*;

    localparam int NR  = 30;
    localparam int CTR = 15;

    typedef struct {
        logic        init;
        logic [18:0] addr;
        logic        bot;
        logic        top;
        logic        ctr;
        logic [18:0] rd;
    } wexp_t;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   load_cyc = 0;
    logic [18:0] prev_rd = '0;
    logic [15:0] exp_step = '0;
    wexp_t       wq[$];
    logic [15:0] sq[$];
    wexp_t       e;

    drum_sweep_ctrl_if #(.ADDR_W(19)) bus ();

    drum_sweep_ctrl #(.NUM_ROWS(NR), .CENTER_ROW(CTR), .ADDR_W(19)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Output monitor: consumes scoreboard entries on each emitted event.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (bus.wr_en) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 32'(bus.wr_addr), 32'hFFFF_FFFF);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    check("init_wr", 32'(bus.init_wr), 32'(e.init));
                    if (!e.init) begin
                        check("shift_en", 32'(bus.shift_en), 32'd1);
                        check("flags", 32'({bus.bottom_flag, bus.top_flag, bus.center_strobe}),
                              32'({e.bot, e.top, e.ctr}));
                        check("rd_addr", 32'(bus.rd_addr), 32'(e.rd));
                    end
                end
            end
            if (int'(bus.init_wr) + int'(bus.load_curr) + int'(bus.shift_en) > 1)
                check("onehot", 32'({bus.init_wr, bus.load_curr, bus.shift_en}), 32'd0);
            if ((bus.bottom_flag | bus.top_flag | bus.center_strobe) && !bus.shift_en)
                check("flag_no_shift", 32'({bus.bottom_flag, bus.top_flag, bus.center_strobe}), 32'd0);
            if (bus.load_curr) begin
                check("load_rd", 32'(bus.rd_addr), 32'd1);
                check("prime_rd", 32'(prev_rd), 32'd0);
                load_cyc = cyc;
            end
            if (bus.step_done) begin
                if (sq.size() == 0) check("done_unexpected", 32'(bus.step_cnt), 32'hFFFF_FFFF);
                else check("step_cnt", 32'(bus.step_cnt), 32'(sq.pop_front()));
                check("sweep_len", 32'(cyc - load_cyc), 32'(2*NR + 1));
            end
        end
        prev_rd = bus.rd_addr;
    end

    task automatic push_sweep();
        wexp_t x;
        for (int r = 0; r < NR; r++) begin
            x.init = 1'b0;
            x.addr = 19'(r);
            x.bot  = (r == 0);
            x.top  = (r == NR-1);
            x.ctr  = (r == CTR);
            x.rd   = (r + 2 < NR) ? 19'(r + 2) : 19'd0;
            wq.push_back(x);
        end
        exp_step = exp_step + 16'd1;
        sq.push_back(exp_step);
    endtask

    task automatic do_init(input bit toggle);
        int   k   = 0;
        int   t   = 0;
        bit   ph  = 1'b0;
        bit   acc = 1'b0;
        wexp_t x;
        while (k < NR && t < 400) begin
            @(posedge clk); #1;
            t++;
            if (acc) k++;
            if (k < NR) begin
                ph = ~ph;
                bus.init_valid = !toggle || ph;
                bus.init_data  = 18'h00400 + 18'(k);
                acc = bus.init_valid && bus.init_ready;
                if (acc) begin
                    x.init = 1'b1; x.addr = 19'(k);
                    x.bot = 1'b0; x.top = 1'b0; x.ctr = 1'b0; x.rd = '0;
                    wq.push_back(x);
                end
            end
        end
        bus.init_valid = 1'b0;
        if (k < NR) check("init_timeout", 32'(k), 32'(NR));
    endtask

    task automatic wait_done(input int n);
        int got = 0;
        int t   = 0;
        while (got < n && t < 400) begin
            @(posedge clk); #1;
            t++;
            if (bus.step_done) got++;
        end
        if (got < n) check("done_timeout", 32'(got), 32'(n));
    endtask

    task automatic check_idle_strobes(input string tag);
        check(tag, 32'({bus.wr_en, bus.init_wr, bus.load_curr, bus.shift_en, bus.bottom_flag,
                        bus.top_flag, bus.center_strobe, bus.step_done}), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.init_data  = '0;
        bus.init_valid = 1'b0;
        bus.run        = 1'b0;
        bus.reinit     = 1'b0;
        bus.audio_req  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.init_ready), 32'd0);
        check("rst_rd", 32'(bus.rd_addr), 32'd0);
        check("rst_wr", 32'(bus.wr_addr), 32'd0);
        check("rst_step", 32'(bus.step_cnt), 32'd0);
        check_idle_strobes("rst_strobes");
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(bus.init_ready), 32'd1);

        // Init with valid held high
        do_init(1'b0);
        check("armed_ready", 32'(bus.init_ready), 32'd0);
        check("init_drained", 32'(wq.size()), 32'd0);

        // Three back-to-back sweeps
        repeat (3) push_sweep();
        bus.run = 1'b1; bus.audio_req = 1'b1;
        wait_done(3);
        bus.run = 1'b0;
        repeat (5) @(posedge clk);
        check("sweeps_drained", 32'(wq.size()), 32'd0);

        // HOLD when audio not ready, resume three cycles later
        push_sweep();
        bus.audio_req = 1'b0; bus.run = 1'b1;
        wait_done(1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_strobes("hold_strobes");
        end
        push_sweep();
        @(posedge clk); #1;
        bus.audio_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i == 1) check("hold_prime_rd", 32'(bus.rd_addr), 32'd0);
            check("hold_load", 32'(bus.load_curr), 32'(i == 3));
        end
        wait_done(1);
        bus.run = 1'b0;

        // Run dropped mid-sweep: sweep completes, then stays armed
        repeat (3) @(posedge clk); #1;
        push_sweep();
        bus.run = 1'b1;
        repeat (20) @(posedge clk); #1;
        bus.run = 1'b0;
        wait_done(1);
        repeat (70) @(posedge clk); #1;
        check("drop_drained", 32'(wq.size()) + 32'(sq.size()), 32'd0);

        // Reinit from ARMED, init with valid toggling
        bus.reinit = 1'b1;
        @(posedge clk); #1;
        bus.reinit = 1'b0;
        check("reinit_ready", 32'(bus.init_ready), 32'd1);
        do_init(1'b1);
        check("reinit_armed", 32'(bus.init_ready), 32'd0);
        check("toggle_drained", 32'(wq.size()), 32'd0);

        // Reset mid-sweep discards progress
        push_sweep();
        bus.run = 1'b1;
        repeat (11) @(posedge clk); #1;
        reset = 1'b1;
        wq.delete(); sq.delete();
        exp_step = '0;
        bus.run = 1'b0;
        @(negedge clk);
        check("midrst_step", 32'(bus.step_cnt), 32'd0);
        check("midrst_rd", 32'(bus.rd_addr), 32'd0);
        check("midrst_wr", 32'(bus.wr_addr), 32'd0);
        check_idle_strobes("midrst_strobes");
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", 32'(bus.init_ready), 32'd1);
        do_init(1'b0);
        push_sweep();
        bus.run = 1'b1; bus.audio_req = 1'b1;
        wait_done(1);
        bus.run = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("final_drained", 32'(wq.size()) + 32'(sq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
